// File: rtl/filter_pkg.sv
// Shared widths and types for the image filter datapath.
// The accumulator is wide enough to hold nine 17-bit products without overflow.
package filter_pkg;

   localparam int unsigned PIX_W    = 8;
   localparam int unsigned COEF_W   = 8;
   localparam int unsigned NUM_TAPS = 9;
   localparam int unsigned ACC_W    = 21;
   localparam int unsigned PIX_MAX  = 255;

   typedef logic        [PIX_W-1:0]  pixel_t;
   typedef logic signed [COEF_W-1:0] coef_t;
   typedef logic signed [ACC_W-1:0]  acc_t;

endpackage

// File: rtl/mac_saturate.sv
// Clamps a signed accumulator to the unsigned pixel range 0..PIX_MAX.
// Shared by the filter blocks that finish with a MAC.
module mac_saturate
   import filter_pkg::*;
(
   input  acc_t   acc,
   output pixel_t pix
);

   // Typed constants keep both comparisons signed
   localparam acc_t ACC_ZERO = '0;
   localparam acc_t ACC_MAX  = acc_t'(PIX_MAX);

   always_comb begin
      pix = '0;
      if (acc <= ACC_ZERO) begin
         pix = '0;
      end else if (acc >= ACC_MAX) begin
         pix = '1;
      end else begin
         pix = acc[PIX_W-1:0];
      end
   end

endmodule

// File: rtl/filter_mac.sv
// 3x3 convolution MAC: nine pixel*coefficient products, adder tree, clamp,
// and a single async-reset output register (one-cycle latency).
module filter_mac
   import filter_pkg::*;
(
   input  logic   clk,
   input  logic   rst_n,
   input  pixel_t array0 [NUM_TAPS],
   input  coef_t  array1 [NUM_TAPS],
   output pixel_t result_pixel
);

   typedef logic signed [PIX_W+COEF_W:0] prod_t;

   prod_t  prod [NUM_TAPS];
   acc_t   lvl1 [5];
   acc_t   lvl2 [3];
   acc_t   lvl3 [2];
   acc_t   sum;
   pixel_t sat;

   // Pixel is zero-extended to 9 bits so the signed multiply treats it as positive
   always_comb begin
      for (int unsigned i = 0; i < NUM_TAPS; i++) begin
         prod[i] = prod_t'($signed({1'b0, array0[i]})) * prod_t'(array1[i]);
      end
   end

   // 9 -> 5 -> 3 -> 2 -> 1, odd leftovers pass straight through a level
   always_comb begin
      lvl1[0] = acc_t'(prod[0]) + acc_t'(prod[1]);
      lvl1[1] = acc_t'(prod[2]) + acc_t'(prod[3]);
      lvl1[2] = acc_t'(prod[4]) + acc_t'(prod[5]);
      lvl1[3] = acc_t'(prod[6]) + acc_t'(prod[7]);
      lvl1[4] = acc_t'(prod[8]);

      lvl2[0] = lvl1[0] + lvl1[1];
      lvl2[1] = lvl1[2] + lvl1[3];
      lvl2[2] = lvl1[4];

      lvl3[0] = lvl2[0] + lvl2[1];
      lvl3[1] = lvl2[2];

      sum     = lvl3[0] + lvl3[1];
   end

   mac_saturate u_sat (
      .acc (sum),
      .pix (sat)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_pixel <= '0;
      end else begin
         result_pixel <= sat;
      end
   end

endmodule

// File: tb/tb_filter_mac.sv
// Randomized and directed bench for filter_mac against a plain-integer
// convolution-and-clamp reference model.
module tb_filter_mac;

   typedef logic        [7:0] pix_arr_t  [9];
   typedef logic signed [7:0] coef_arr_t [9];

   logic      clk;
   logic      rst_n;
   pix_arr_t  a0;
   coef_arr_t a1;
   logic [7:0] result_pixel;

   int checks = 0;
   int errors = 0;

   filter_mac dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .array0       (a0),
      .array1       (a1),
      .result_pixel (result_pixel)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int model(input pix_arr_t p, input coef_arr_t c);
      int s = 0;
      for (int i = 0; i < 9; i++) s += int'(p[i]) * int'(c[i]);
      if (s <= 0) return 0;
      if (s >= 255) return 255;
      return s;
   endfunction

   task automatic randomize_inputs(input bit small_coef);
      for (int i = 0; i < 9; i++) begin
         a0[i] = 8'($urandom_range(0, 255));
         if (small_coef) a1[i] = 8'($signed($urandom_range(0, 6)) - 3);
         else            a1[i] = 8'($urandom_range(0, 255));
      end
   endtask

   task automatic set_all(input int p, input int c);
      for (int i = 0; i < 9; i++) begin
         a0[i] = 8'(p);
         a1[i] = 8'(c);
      end
   endtask

   // Random pixels everywhere, zero coefficients; callers then program a few taps
   task automatic clear_kernel();
      for (int i = 0; i < 9; i++) begin
         a0[i] = 8'($urandom_range(0, 255));
         a1[i] = '0;
      end
   endtask

   // Inputs are already on the bus; register them and compare one edge later
   task automatic apply(input string tag);
      int exp;
      exp = model(a0, a1);
      @(posedge clk);
      #1;
      check(tag, int'(result_pixel), exp);
   endtask

   initial begin
      int exp;

      // Asynchronous reset before any clock edge
      rst_n = 1'b1;
      randomize_inputs(1'b0);
      #1 rst_n = 1'b0;
      #1 check("reset_async", int'(result_pixel), 0);

      for (int k = 0; k < 3; k++) begin
         randomize_inputs(1'b0);
         @(posedge clk);
         #1 check("reset_hold", int'(result_pixel), 0);
      end

      // Release between edges: output holds 0 until the next edge
      clear_kernel();
      a0[4] = 8'd77;
      a1[4] = 8'sd1;
      rst_n = 1'b1;
      #1 check("reset_release", int'(result_pixel), 0);
      @(posedge clk);
      #1 check("first_after_reset", int'(result_pixel), 77);

      clear_kernel();
      a0[4] = 8'd100;
      a1[4] = 8'sd1;
      apply("identity");
      check("identity_const", int'(result_pixel), 100);

      set_all(255, 1);    apply("sat_pos_1");
      check("sat_pos_1_const", int'(result_pixel), 255);
      set_all(255, 127);  apply("sat_pos_127");
      set_all(200, -1);   apply("sat_neg");
      check("sat_neg_const", int'(result_pixel), 0);
      set_all(200, 0);    apply("zero_coef");
      set_all(10, 2);     apply("mid_range");
      check("mid_range_const", int'(result_pixel), 180);
      set_all(0, 0);
      a0[8] = 8'd50;
      a1[8] = 8'sd3;
      apply("tap8");
      check("tap8_const", int'(result_pixel), 150);

      // Sums landing exactly on the clamp boundaries
      clear_kernel();
      a0[0] = 8'd100; a1[0] = 8'sd1;
      a0[5] = 8'd100; a1[5] = -8'sd1;
      apply("sum_0");
      check("sum_0_const", int'(result_pixel), 0);
      clear_kernel(); a0[3] = 8'd1;   a1[3] = 8'sd1; apply("sum_1");
      check("sum_1_const", int'(result_pixel), 1);
      clear_kernel(); a0[6] = 8'd254; a1[6] = 8'sd1; apply("sum_254");
      check("sum_254_const", int'(result_pixel), 254);
      clear_kernel(); a0[2] = 8'd255; a1[2] = 8'sd1; apply("sum_255");
      check("sum_255_const", int'(result_pixel), 255);
      clear_kernel(); a0[7] = 8'd128; a1[7] = 8'sd2; apply("sum_256");
      check("sum_256_const", int'(result_pixel), 255);

      // Reset mid-stream discards the value being set up
      randomize_inputs(1'b1);
      apply("pre_midreset");
      randomize_inputs(1'b1);
      #2 rst_n = 1'b0;
      #1 check("midreset_async", int'(result_pixel), 0);
      @(posedge clk);
      #1 check("midreset_hold", int'(result_pixel), 0);
      rst_n = 1'b1;
      apply("after_midreset");

      // Random regression; small kernels keep many sums inside 0..255
      for (int n = 0; n < 1000; n++) begin
         randomize_inputs(n[0]);
         apply("random");
         if (n % 97 == 0) begin
            exp = model(a0, a1);
            #7 check("random_stable", int'(result_pixel), exp);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
